router_pkt_tx: RTL and testbench



---
 rtl/router_pkt_tx_if.sv | 10 +
 rtl/router_pkt_tx.sv | 169 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request handshake bundle for the serial packet transmitter
interface router_pkt_tx_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_da;
    logic [31:0] in_data;

    modport master (output in_valid, output in_da, output in_data, input in_ready);
    modport slave  (input in_valid, input in_da, input in_data, output in_ready);
endinterface

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered serial packet transmitter driving a router ingress port
module router_pkt_tx #(
    parameter int DEPTH   = 2,
    parameter int PAD_LEN = 10,
    parameter int GAP     = 1
) (
    input  logic          clock,
    input  logic          reset,
    router_pkt_tx_if.slave req,
    output logic          frame_n,
    output logic          valid_n,
    output logic          di,
    output logic          busy,
    output logic [7:0]    tx_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [4:0]    PAD_LAST = (PAD_LEN > 0) ? 5'(PAD_LEN - 1) : 5'd0;
    localparam logic [4:0]    GAP_LAST = 5'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_GAP} state_t;

    logic [3:0]    mem_da   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fill;
    logic          ready_en;
    logic          push, pop;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [3:0]  da_sr, da_nx;
    logic [31:0] data_sr, data_nx;
    logic        frame_nx, valid_nx, di_nx, count_inc;

    // ready_en keeps in_ready low through reset and rises on the first edge after release
    assign req.in_ready = ready_en && (fill != FULL_CNT);
    assign push         = req.in_valid && req.in_ready;
    assign busy         = (state != S_IDLE) || (fill != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_da[wr_ptr]   <= req.in_da;
            mem_data[wr_ptr] <= req.in_data;
        end
    end

    // Next-state logic also computes the line values for the following cycle, so the
    // serial outputs come straight from flops.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        da_nx     = da_sr;
        data_nx   = data_sr;
        frame_nx  = 1'b1;
        valid_nx  = 1'b1;
        di_nx     = 1'b0;
        pop       = 1'b0;
        count_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill != '0) begin
                    pop      = 1'b1;
                    state_nx = S_ADDR;
                    cnt_nx   = '0;
                    da_nx    = {1'b0, mem_da[rd_ptr][3:1]};
                    data_nx  = mem_data[rd_ptr];
                    frame_nx = 1'b0;
                    di_nx    = mem_da[rd_ptr][0];
                end
            end
            S_ADDR: begin
                frame_nx = 1'b0;
                if (cnt != 5'd3) begin
                    cnt_nx = cnt + 5'd1;
                    di_nx  = da_sr[0];
                    da_nx  = da_sr >> 1;
                end else if (PAD_LEN == 0) begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                    valid_nx = 1'b0;
                    di_nx    = data_sr[0];
                    data_nx  = data_sr >> 1;
                end else begin
                    state_nx = S_PAD;
                    cnt_nx   = '0;
                    di_nx    = 1'b1;
                end
            end
            S_PAD: begin
                frame_nx = 1'b0;
                if (cnt != PAD_LAST) begin
                    cnt_nx = cnt + 5'd1;
                    di_nx  = 1'b1;
                end else begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                    valid_nx = 1'b0;
                    di_nx    = data_sr[0];
                    data_nx  = data_sr >> 1;
                end
            end
            S_DATA: begin
                if (cnt != 5'd31) begin
                    cnt_nx   = cnt + 5'd1;
                    valid_nx = 1'b0;
                    frame_nx = (cnt == 5'd30);
                    di_nx    = data_sr[0];
                    data_nx  = data_sr >> 1;
                end else begin
                    state_nx  = S_GAP;
                    cnt_nx    = '0;
                    count_inc = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt != GAP_LAST) begin
                    cnt_nx = cnt + 5'd1;
                end else begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            da_sr    <= '0;
            data_sr  <= '0;
            frame_n  <= 1'b1;
            valid_n  <= 1'b1;
            di       <= 1'b0;
            tx_count <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            da_sr   <= da_nx;
            data_sr <= data_nx;
            frame_n <= frame_nx;
            valid_n <= valid_nx;
            di      <= di_nx;
            if (count_inc) tx_count <= tx_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard bench for router_pkt_tx (default and PAD_LEN=0/GAP=3 builds)
module tb_router_pkt_tx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_pkt_tx_if if0 ();
    router_pkt_tx_if if1 ();

    logic [1:0] fr, vn, dv, bsy;
    logic [7:0] tx0, tx1;

    router_pkt_tx dut0 (
        .clock(clock), .reset(reset), .req(if0),
        .frame_n(fr[0]), .valid_n(vn[0]), .di(dv[0]), .busy(bsy[0]), .tx_count(tx0)
    );
    router_pkt_tx #(.DEPTH(2), .PAD_LEN(0), .GAP(3)) dut1 (
        .clock(clock), .reset(reset), .req(if1),
        .frame_n(fr[1]), .valid_n(vn[1]), .di(dv[1]), .busy(bsy[1]), .tx_count(tx1)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input bit ok, input longint act, input longint req_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
        end
    endfunction

    logic [35:0] expq0[$];
    logic [35:0] expq1[$];
    int          fall_t0[$];

    int          padl[2]      = '{10, 0};
    int          minsp[2]     = '{48, 40};
    int          ph[2]        = '{0, 0};
    int          idx[2]       = '{0, 0};
    int          last_fall[2] = '{-1, -1};
    logic [3:0]  ada[2];
    logic [31:0] adata[2];
    int          cyc = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0;
                idx[k] = 0;
                last_fall[k] = -1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [35:0] e;
                int          occ;
                logic [1:0]  dl;
                case (ph[k])
                    0: begin
                        if (!fr[k]) begin
                            check("addr0_valid_n", vn[k] == 1'b1, vn[k], 1);
                            if (last_fall[k] >= 0)
                                check("frame_spacing", (cyc - last_fall[k]) >= minsp[k], cyc - last_fall[k], minsp[k]);
                            last_fall[k] = cyc;
                            if (k == 0) fall_t0.push_back(cyc);
                            ada[k][0] = dv[k];
                            idx[k] = 1;
                            ph[k] = 1;
                        end else begin
                            check("idle_lines", {fr[k], vn[k], dv[k]} == 3'b110, {fr[k], vn[k], dv[k]}, 3'b110);
                        end
                    end
                    1: begin
                        check("addr_lines", {fr[k], vn[k]} == 2'b01, {fr[k], vn[k]}, 2'b01);
                        ada[k][idx[k]] = dv[k];
                        idx[k]++;
                        if (idx[k] == 4) begin
                            ph[k] = (padl[k] > 0) ? 2 : 3;
                            idx[k] = 0;
                        end
                    end
                    2: begin
                        check("pad_lines", {fr[k], vn[k], dv[k]} == 3'b011, {fr[k], vn[k], dv[k]}, 3'b011);
                        idx[k]++;
                        if (idx[k] == padl[k]) begin
                            ph[k] = 3;
                            idx[k] = 0;
                        end
                    end
                    default: begin
                        if (idx[k] == 0)
                            check("valid_fall_offset", (cyc - last_fall[k]) == 4 + padl[k], cyc - last_fall[k], 4 + padl[k]);
                        dl = {(idx[k] == 31), 1'b0};
                        check("data_lines", {fr[k], vn[k]} == dl, {fr[k], vn[k]}, dl);
                        adata[k][idx[k]] = dv[k];
                        if (idx[k] == 31) begin
                            ph[k] = 0;
                            idx[k] = 0;
                            if ((k == 0 ? expq0.size() : expq1.size()) == 0) begin
                                check("unexpected_packet", 1'b0, {ada[k], adata[k]}, 0);
                            end else begin
                                e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
                                check("pkt_da", ada[k] == e[35:32], ada[k], e[35:32]);
                                check("pkt_data", adata[k] == e[31:0], adata[k], e[31:0]);
                            end
                        end else begin
                            idx[k]++;
                        end
                    end
                endcase
                // Queued entries minus the one being shifted out equals FIFO fill.
                occ = ((k == 0) ? expq0.size() : expq1.size()) - ((ph[k] != 0) ? 1 : 0);
                if (k == 0) check("in_ready_vs_fill", if0.in_ready == (occ < 2), if0.in_ready, occ < 2);
                else        check("in_ready_vs_fill", if1.in_ready == (occ < 2), if1.in_ready, occ < 2);
            end
        end
    end

    int last_wait;

    task automatic push(input int k, input logic [3:0] da, input logic [31:0] d);
        int t;
        logic rdy;
        t = 0;
        @(negedge clock);
        if (k == 0) begin if0.in_valid = 1'b1; if0.in_da = da; if0.in_data = d; end
        else        begin if1.in_valid = 1'b1; if1.in_da = da; if1.in_data = d; end
        rdy = (k == 0) ? if0.in_ready : if1.in_ready;
        while (!rdy && t < 300) begin
            @(negedge clock);
            t++;
            rdy = (k == 0) ? if0.in_ready : if1.in_ready;
        end
        last_wait = t;
        if (!rdy) begin
            check("push_timeout", 1'b0, t, 300);
        end else begin
            @(posedge clock);
            if (k == 0) expq0.push_back({da, d});
            else        expq1.push_back({da, d});
        end
        #1;
        if (k == 0) if0.in_valid = 1'b0;
        else        if1.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (bsy[k] && t < 2000);
        check("idle_timeout", !bsy[k], t, 2000);
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_da = '0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_da = '0; if1.in_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_lines0", {fr[0], vn[0], dv[0]} == 3'b110, {fr[0], vn[0], dv[0]}, 3'b110);
        check("reset_lines1", {fr[1], vn[1], dv[1]} == 3'b110, {fr[1], vn[1], dv[1]}, 3'b110);
        check("reset_in_ready", if0.in_ready == 1'b0, if0.in_ready, 0);
        check("reset_busy", bsy == 2'b00, bsy, 0);
        check("reset_tx_count", tx0 == 8'd0, tx0, 0);
        @(negedge clock);
        #1 reset = 1'b0;

        // idle hygiene
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_busy", bsy[0] == 1'b0, bsy[0], 0);
        end

        // single packet
        push(0, 4'd7, 32'hDEAD_BEEF);
        wait_idle(0);
        check("tx_count_single", tx0 == 8'd1, tx0, 1);

        // back-to-back, fourth request must stall on a full FIFO
        fall_t0.delete();
        push(0, 4'd2, 32'd1);
        push(0, 4'd2, 32'd2);
        push(0, 4'd2, 32'd3);
        push(0, 4'd2, 32'd4);
        check("b2b_fourth_waits", last_wait >= 40, last_wait, 40);
        wait_idle(0);
        check("b2b_falls", fall_t0.size() == 4, fall_t0.size(), 4);
        for (int i = 1; i < fall_t0.size(); i++)
            check("b2b_spacing", fall_t0[i] - fall_t0[i-1] == 48, fall_t0[i] - fall_t0[i-1], 48);
        check("tx_count_b2b", tx0 == 8'd5, tx0, 5);

        // PAD_LEN=0 / GAP=3 build
        push(1, 4'd0, 32'h1234_5678);
        push(1, 4'd0, 32'hA5A5_0F0F);
        wait_idle(1);
        check("tx_count_pad0", tx1 == 8'd2, tx1, 2);

        // reset during payload bit 10
        push(0, 4'd9, 32'hCAFE_F00D);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clock);
                #1;
                t++;
            end while (!(ph[0] == 3 && idx[0] == 11) && t < 300);
            check("reach_bit10", ph[0] == 3 && idx[0] == 11, idx[0], 11);
        end
        reset = 1'b1;
        #1;
        check("midrst_lines", {fr[0], vn[0], dv[0]} == 3'b110, {fr[0], vn[0], dv[0]}, 3'b110);
        check("midrst_in_ready", if0.in_ready == 1'b0, if0.in_ready, 0);
        check("midrst_busy", bsy[0] == 1'b0, bsy[0], 0);
        check("midrst_tx_count", tx0 == 8'd0, tx0, 0);
        expq0.delete();
        expq1.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("postrst_empty", bsy[0] == 1'b0, bsy[0], 0);
        check("postrst_tx_count", tx0 == 8'd0, tx0, 0);
        push(0, 4'd4, 32'h0F0F_1234);
        wait_idle(0);
        check("tx_count_postrst", tx0 == 8'd1, tx0, 1);

        // wrap: 255 more packets take tx_count from 1 back to 0
        for (int i = 1; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            push(0, b[3:0], {b, ~b, b ^ 8'h5A, 8'hC3});
        end
        wait_idle(0);
        check("tx_count_wrap", tx0 == 8'd0, tx0, 0);
        check("wrap_queue_drained", expq0.size() == 0, expq0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
